mem_access_unit: RTL

Memory-stage load/store engine for the pipelined ARM core. It is the producer side of the MEM/WB pipeline register. It takes EX/MEM-stage operands and drives a multi-cycle data-memory handshake. It returns a formatted load result plus the pass-through writeback fields (rd, link, writeback enable, CPSR flags, ALU result) to the MEM/WB register, and stalls the front of the pipeline while an access is outstanding.

---
 rtl/mem_access_unit.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Memory-stage load/store engine: drives a req/ack data-memory handshake and
// produces the MEM/WB result slot, stalling upstream while an access is open.
module mem_access_unit #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic              in_byte,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_store_data,
  input  logic [3:0]        in_rd,
  input  logic              in_link,
  input  logic              in_wb_en,
  input  logic [3:0]        in_cpsr,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              out_valid,
  output logic [31:0]       out_data_mem,
  output logic [31:0]       out_write_data,
  output logic [3:0]        out_rd,
  output logic              out_link,
  output logic              out_wb_en,
  output logic [3:0]        out_cpsr,
  output logic              fault
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic              r_byte;
  logic [31:0]       r_wdata;
  logic [3:0]        r_be;
  logic [3:0]        r_rd;
  logic              r_link;
  logic              r_wb_en;
  logic [3:0]        r_cpsr;
  logic [CNT_W-1:0]  r_cnt;

  logic              r_out_valid;
  logic [31:0]       r_out_data_mem;
  logic [31:0]       r_out_write_data;
  logic [3:0]        r_out_rd;
  logic              r_out_link;
  logic              r_out_wb_en;
  logic [3:0]        r_out_cpsr;
  logic              r_fault;

  logic              w_mem_op;
  logic              w_misalign;
  logic              w_accept;
  logic              w_alu_take;
  logic              w_mis_take;
  logic              w_ack_take;
  logic              w_tmo_take;
  logic              w_stall;
  logic [3:0]        w_be_in;
  logic [31:0]       w_wdata_in;
  logic [7:0]        w_lane;
  logic [31:0]       w_load_fmt;

  assign w_mem_op   = in_valid & (in_mem_read | in_mem_write);
  assign w_misalign = ~in_byte & (in_addr[1:0] != 2'b00);
  assign w_be_in    = in_byte ? (4'b0001 << in_addr[1:0]) : 4'b1111;
  assign w_wdata_in = in_byte ? {4{in_store_data[7:0]}} : in_store_data;

  always_comb begin
    w_lane = mem_rdata[7:0];
    case (r_addr[1:0])
      2'd1:    w_lane = mem_rdata[15:8];
      2'd2:    w_lane = mem_rdata[23:16];
      2'd3:    w_lane = mem_rdata[31:24];
      default: w_lane = mem_rdata[7:0];
    endcase
  end

  // Stores return zero; byte loads are zero-extended from the addressed lane.
  assign w_load_fmt = r_we   ? 32'd0 :
                      r_byte ? {24'd0, w_lane} : mem_rdata;

  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    w_accept    = 1'b0;
    w_alu_take  = 1'b0;
    w_mis_take  = 1'b0;
    w_ack_take  = 1'b0;
    w_tmo_take  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_mem_op) begin
          w_stall     = 1'b1;
          w_accept    = 1'b1;
          w_mis_take  = w_misalign;
          w_state_nxt = w_misalign ? S_DONE : S_REQ;
        end else if (in_valid) begin
          w_alu_take = 1'b1;
        end
      end
      S_REQ: begin
        w_stall = 1'b1;
        if (mem_ack) begin
          w_ack_take  = 1'b1;
          w_state_nxt = S_DONE;
        end else if (r_cnt == CNT_LAST) begin
          w_tmo_take  = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_addr           <= '0;
      r_we             <= 1'b0;
      r_byte           <= 1'b0;
      r_wdata          <= '0;
      r_be             <= '0;
      r_rd             <= '0;
      r_link           <= 1'b0;
      r_wb_en          <= 1'b0;
      r_cpsr           <= '0;
      r_cnt            <= '0;
      r_out_valid      <= 1'b0;
      r_out_data_mem   <= '0;
      r_out_write_data <= '0;
      r_out_rd         <= '0;
      r_out_link       <= 1'b0;
      r_out_wb_en      <= 1'b0;
      r_out_cpsr       <= '0;
      r_fault          <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= 1'b0;
      r_cnt       <= (r_state == S_REQ) ? r_cnt + CNT_W'(1) : '0;
      if (w_accept) begin
        r_addr  <= in_addr;
        r_we    <= in_mem_write;
        r_byte  <= in_byte;
        r_wdata <= w_wdata_in;
        r_be    <= w_be_in;
        r_rd    <= in_rd;
        r_link  <= in_link;
        r_wb_en <= in_wb_en;
        r_cpsr  <= in_cpsr;
      end
      // ALU ops and misaligned faults complete straight from the inputs.
      if (w_alu_take || w_mis_take) begin
        r_out_valid      <= 1'b1;
        r_out_data_mem   <= '0;
        r_out_write_data <= 32'(in_addr);
        r_out_rd         <= in_rd;
        r_out_link       <= in_link;
        r_out_wb_en      <= in_wb_en & ~w_mis_take;
        r_out_cpsr       <= in_cpsr;
        r_fault          <= w_mis_take;
      end
      if (w_ack_take || w_tmo_take) begin
        r_out_valid      <= 1'b1;
        r_out_data_mem   <= w_tmo_take ? 32'd0 : w_load_fmt;
        r_out_write_data <= 32'(r_addr);
        r_out_rd         <= r_rd;
        r_out_link       <= r_link;
        r_out_wb_en      <= r_wb_en & ~w_tmo_take;
        r_out_cpsr       <= r_cpsr;
        r_fault          <= w_tmo_take;
      end
    end
  end

  assign stall          = w_stall;
  assign mem_req        = (r_state == S_REQ);
  assign mem_we         = r_we;
  assign mem_addr       = {r_addr[ADDR_W-1:2], 2'b00};
  assign mem_wdata      = r_wdata;
  assign mem_be         = r_be;
  assign out_valid      = r_out_valid;
  assign out_data_mem   = r_out_data_mem;
  assign out_write_data = r_out_write_data;
  assign out_rd         = r_out_rd;
  assign out_link       = r_out_link;
  assign out_wb_en      = r_out_wb_en;
  assign out_cpsr       = r_out_cpsr;
  assign fault          = r_fault;

endmodule
